// File: rtl/data_mem_access_pkg.sv
// Shared constants for the data RAM access controller: RV32I load/store width codes,
// FSM state encoding and the request legality check.
package data_mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StResp
  } state_e;

  // High when the request must be answered with an error and no RAM access.
  function automatic logic req_bad(input logic [2:0] funct3, input logic [1:0] addr_lo,
                                   input logic we);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = (addr_lo != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half lane steering: extracts and extends load data from a RAM word and merges
// sub-word store data into a previously read word.
module mem_lane_align
  import data_mem_access_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'h0, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'h0, half_sel};
      default: load_data_o = word_i;
    endcase
  end

  always_comb begin
    store_word_o = word_i;
    case (funct3_i)
      F3_B:    store_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H:    store_word_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: store_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem_access.sv
// Requester-side controller for the word-wide data RAM: RV32I loads/stores with lane
// extraction on loads and read-modify-write for byte/half stores.
module data_mem_access
  import data_mem_access_pkg::*;
#(
  parameter int unsigned MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;

  logic [31:0] align_word;
  logic [31:0] load_data;
  logic [31:0] store_word;

  // Upper byte-address bits wrap within the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:MEM_AW+2];

  // Live RAM data while reading, captured word while writing.
  assign align_word = (state_q == StRd) ? mem_rdata : merge_q;

  mem_lane_align u_lane_align (
    .funct3_i     (funct3_q),
    .addr_lo_i    (addr_lo_q),
    .word_i       (align_word),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      wdata_q      <= 32'h0;
      merge_q      <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = mem_addr_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d      = req_we;
          funct3_d  = req_funct3;
          addr_lo_d = req_addr[1:0];
          wdata_d   = req_wdata;
          if (req_bad(req_funct3, req_addr[1:0], req_we)) begin
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
            state_d      = StResp;
          end else begin
            mem_addr_d = req_addr[MEM_AW+1:2];
            state_d    = (req_we && (req_funct3 == F3_W)) ? StWr : StRd;
          end
        end
      end
      StRd: begin
        if (we_q) begin
          merge_d = mem_rdata;
          state_d = StWr;
        end else begin
          resp_rdata_d = load_data;
          resp_err_d   = 1'b0;
          state_d      = StResp;
        end
      end
      StWr: begin
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        state_d      = StResp;
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_rdata = resp_rdata_q;
    resp_err   = resp_err_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = store_word;
    // Reset must suppress an in-flight write in the same cycle.
    mem_we     = (state_q == StWr) && !rst;
  end

endmodule

// File: tb/tb_data_mem_access.sv
// Self-checking bench for data_mem_access: behavioural RAM plus a scoreboard of expected
// responses and latencies.
module tb_data_mem_access;
  import data_mem_access_pkg::*;

  localparam int unsigned MEM_AW = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  always #5 clk = ~clk;

  data_mem_access #(.MEM_AW(MEM_AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  logic [31:0] ram [4096];
  logic        do_preload;

  assign mem_rdata = ram[mem_addr];

  always @(posedge clk) begin
    if (do_preload) ram[256] <= 32'h8899AABB;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  int we_pulses = 0;
  always @(negedge clk) if (mem_we) we_pulses++;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          pulses;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Issue one request, then check response, latency, write pulses and return to idle.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                        input int exp_pulses, input int hold);
    exp_t e;
    int   lat;
    int   p0;
    e.rdata  = exp_rdata;
    e.err    = exp_err;
    e.lat    = exp_lat;
    e.pulses = exp_pulses;
    sb_q.push_back(e);
    @(negedge clk);
    p0         = we_pulses;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb_q.pop_front();
    check_eq({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    check_eq({tag, " rdata"}, resp_rdata, e.rdata);
    check_eq({tag, " err"}, 32'(resp_err), 32'(e.err));
    check_eq({tag, " latency"}, 32'(lat), 32'(e.lat));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h400;
        req_wdata  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        check_eq({tag, " stall valid"}, 32'(resp_valid), 32'd1);
        check_eq({tag, " stall rdata"}, resp_rdata, e.rdata);
        check_eq({tag, " stall ready"}, 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq({tag, " back idle"}, 32'({resp_valid, req_ready}), 32'b01);
    check_eq({tag, " we pulses"}, 32'(we_pulses - p0), 32'(e.pulses));
  endtask

  initial begin
    int p0;
    rst        = 1'b1;
    do_preload = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset req_ready", 32'(req_ready), 32'd1);
    check_eq("reset resp_valid", 32'(resp_valid), 32'd0);
    check_eq("reset resp_err", 32'(resp_err), 32'd0);
    check_eq("reset resp_rdata", resp_rdata, 32'h0);
    check_eq("reset mem_we", 32'(mem_we), 32'd0);
    check_eq("reset mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst        = 1'b0;
    do_preload = 1'b0;

    do_req("LB 403",  1'b0, F3_B,  32'h403, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0, 0);
    do_req("LBU 403", 1'b0, F3_BU, 32'h403, 32'h0, 32'h00000088, 1'b0, 2, 0, 0);
    do_req("LH 402",  1'b0, F3_H,  32'h402, 32'h0, 32'hFFFF8899, 1'b0, 2, 0, 0);
    do_req("LHU 400", 1'b0, F3_HU, 32'h400, 32'h0, 32'h0000AABB, 1'b0, 2, 0, 0);
    do_req("LW 400",  1'b0, F3_W,  32'h400, 32'h0, 32'h8899AABB, 1'b0, 2, 0, 0);
    do_req("SB 401",  1'b1, F3_B,  32'h401, 32'h12345677, 32'h0, 1'b0, 3, 1, 0);
    check_eq("ram after SB", ram[256], 32'h889977BB);
    do_req("LW after SB", 1'b0, F3_W, 32'h400, 32'h0, 32'h889977BB, 1'b0, 2, 0, 0);
    do_req("SH 402",  1'b1, F3_H,  32'h402, 32'h0000CAFE, 32'h0, 1'b0, 3, 1, 0);
    check_eq("ram after SH", ram[256], 32'hCAFE77BB);
    do_req("LW wrap", 1'b0, F3_W,  32'h80000400, 32'h0, 32'hCAFE77BB, 1'b0, 2, 0, 0);
    do_req("LB 400",  1'b0, F3_B,  32'h400, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 0, 0);
    do_req("LB 401",  1'b0, F3_B,  32'h401, 32'h0, 32'h00000077, 1'b0, 2, 0, 0);
    do_req("LH 402b", 1'b0, F3_H,  32'h402, 32'h0, 32'hFFFFCAFE, 1'b0, 2, 0, 0);
    do_req("LHU 402", 1'b0, F3_HU, 32'h402, 32'h0, 32'h0000CAFE, 1'b0, 2, 0, 0);
    do_req("SW 404",  1'b1, F3_W,  32'h404, 32'h01020304, 32'h0, 1'b0, 2, 1, 0);
    do_req("LW 404",  1'b0, F3_W,  32'h404, 32'h0, 32'h01020304, 1'b0, 2, 0, 0);
    do_req("LW 402 err", 1'b0, F3_W, 32'h402, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("SH 401 err", 1'b1, F3_H, 32'h401, 32'hFFFF, 32'h0, 1'b1, 1, 0, 0);
    do_req("f3 011 err", 1'b0, 3'b011, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("SBU err", 1'b1, F3_BU, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    check_eq("ram after errs", ram[256], 32'hCAFE77BB);
    do_req("LW stall", 1'b0, F3_W, 32'h400, 32'h0, 32'hCAFE77BB, 1'b0, 2, 0, 5);
    check_eq("ram after stall", ram[256], 32'hCAFE77BB);

    // Reset lands while an SB sits in its write cycle.
    @(negedge clk);
    p0         = we_pulses;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_B;
    req_addr   = 32'h400;
    req_wdata  = 32'h11;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst SB in WR", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst gates mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst ram kept", ram[256], 32'hCAFE77BB);
    check_eq("rst no pulse", 32'(we_pulses - p0), 32'd0);
    check_eq("rst req_ready", 32'(req_ready), 32'd1);
    check_eq("rst resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst resp_err", 32'(resp_err), 32'd0);
    check_eq("rst resp_rdata", resp_rdata, 32'h0);
    check_eq("rst mem_addr", 32'(mem_addr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
